// File: rtl/tick_gen_pkg.sv
// Shared constants, channel command type and divisor helper for the tick generator.
// Default divisors assume a 100 MHz master clock.
package tick_gen_pkg;

    localparam int unsigned DEF_CNT_W = 27;
    localparam int unsigned CLK_HZ    = 100_000_000;
    localparam int unsigned CH_IDX_W  = 4;

    // Per-channel command chosen by the top-level priority logic each cycle.
    typedef enum logic [1:0] {
        ChCount,   // normal counting
        ChHalt,    // clear count, tick and done (run low or global restart)
        ChReload   // clear count and tick, keep done (divisor write)
    } ch_op_e;

    // Divisor giving freq_hz ticks per second from clk_hz; a zero frequency saturates.
    function automatic logic [DEF_CNT_W-1:0] div_for_freq(input int unsigned clk_hz,
                                                          input int unsigned freq_hz);
        if (freq_hz == 0) begin
            return '1;
        end
        return DEF_CNT_W'(clk_hz / freq_hz - 1);
    endfunction

    localparam logic [DEF_CNT_W-1:0] DIV_1HZ   = div_for_freq(CLK_HZ, 1);
    localparam logic [DEF_CNT_W-1:0] DIV_500HZ = div_for_freq(CLK_HZ, 500);
    localparam logic [DEF_CNT_W-1:0] DIV_1KHZ  = div_for_freq(CLK_HZ, 1000);

    localparam logic [3*DEF_CNT_W-1:0] DEF_DIVS = {DIV_1HZ, DIV_500HZ, DIV_1KHZ};

endpackage

// File: rtl/tick_channel.sv
// One tick channel: counter, divisor register, registered tick and sticky one-shot done.
// The command input is already priority-resolved by the parent.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int unsigned       CNT_W     = DEF_CNT_W,
    parameter logic [CNT_W-1:0]  RESET_DIV = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  ch_op_e           op,
    input  logic             div_we,
    input  logic [CNT_W-1:0] div_wdata,
    input  logic             oneshot,
    output logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             terminal;

    assign terminal = (cnt_q == div_q);

    always_comb begin
        div_d  = div_we ? div_wdata : div_q;
        cnt_d  = '0;
        tick_d = 1'b0;
        done_d = done_q;
        unique case (op)
            ChHalt: begin
                done_d = 1'b0;
            end
            ChReload: begin
                done_d = done_q;
            end
            ChCount: begin
                // A finished one-shot channel parks at zero until re-armed.
                if (!done_q) begin
                    if (terminal) begin
                        tick_d = 1'b1;
                        done_d = oneshot;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                done_d = done_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= RESET_DIV;
            tick_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            done_q <= done_d;
        end
    end

    assign tick = tick_q;
    assign done = done_q;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel programmable enable-pulse generator: write-address decode and command
// priority (restart > write > run low > count) feeding N_CH tick_channel instances.
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int unsigned              N_CH        = 3,
    parameter int unsigned              CNT_W       = DEF_CNT_W,
    parameter logic [N_CH*CNT_W-1:0]    DEFAULT_DIV = DEF_DIVS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     run,
    input  logic [N_CH-1:0]     oneshot,
    input  logic                sync_restart,
    input  logic                wr_en,
    input  logic [CH_IDX_W-1:0] wr_ch,
    input  logic [CNT_W-1:0]    wr_div,
    output logic [N_CH-1:0]     tick,
    output logic [N_CH-1:0]     done
);

    logic [N_CH-1:0] wr_hit;
    ch_op_e          ch_op [N_CH];

    // Out-of-range channel indices match no channel, so such writes vanish.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wr_hit[i] = wr_en && (wr_ch == CH_IDX_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            if (sync_restart) begin
                ch_op[i] = ChHalt;
            end else if (wr_hit[i]) begin
                ch_op[i] = ChReload;
            end else if (!run[i]) begin
                ch_op[i] = ChHalt;
            end else begin
                ch_op[i] = ChCount;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W     (CNT_W),
            .RESET_DIV (DEFAULT_DIV[g*CNT_W +: CNT_W])
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .op        (ch_op[g]),
            .div_we    (wr_hit[g]),
            .div_wdata (wr_div),
            .oneshot   (oneshot[g]),
            .tick      (tick[g]),
            .done      (done[g])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// Randomised and directed bench for tick_generator against a phase-count reference model.
module tb_tick_generator;

    localparam int unsigned N_CH  = 3;
    localparam int unsigned CNT_W = 27;
    localparam logic [N_CH*CNT_W-1:0] TB_DIV = {27'd9, 27'd4, 27'd1};

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N_CH-1:0]  run = '0;
    logic [N_CH-1:0]  oneshot = '0;
    logic             sync_restart = 1'b0;
    logic             wr_en = 1'b0;
    logic [3:0]       wr_ch = '0;
    logic [CNT_W-1:0] wr_div = '0;
    logic [N_CH-1:0]  tick, done;
    logic [N_CH-1:0]  tick_def, done_def;

    always #5 clk = ~clk;

    tick_generator #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (TB_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .oneshot      (oneshot),
        .sync_restart (sync_restart),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_div       (wr_div),
        .tick         (tick),
        .done         (done)
    );

    // Default-parameter instance, used only to observe the reset divisors.
    tick_generator dut_def (
        .clk          (clk),
        .rst          (rst),
        .run          ('0),
        .oneshot      ('0),
        .sync_restart (1'b0),
        .wr_en        (1'b0),
        .wr_ch        (4'd0),
        .wr_div       (27'd0),
        .tick         (tick_def),
        .done         (done_def)
    );

    // Model: edges counted since the channel's last phase anchor; a tick lands on every
    // multiple of (div+1).
    int unsigned     div_m [N_CH];
    longint          k_m [N_CH];
    logic [N_CH-1:0] tick_m, done_m;
    int unsigned     n_cmp = 0;
    int unsigned     n_err = 0;
    int              first_tick [N_CH];
    int unsigned     edge_no;
    int unsigned     ch1_ticks;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        div_m[0] = 1;
        div_m[1] = 4;
        div_m[2] = 9;
        for (int i = 0; i < N_CH; i++) begin
            k_m[i] = 0;
            first_tick[i] = -1;
        end
        tick_m  = '0;
        done_m  = '0;
        edge_no = 0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < N_CH; i++) begin
            logic hit;
            hit = wr_en && (int'(wr_ch) == i);
            if (hit) div_m[i] = int'(wr_div);
            if (sync_restart) begin
                k_m[i] = 0; tick_m[i] = 1'b0; done_m[i] = 1'b0;
            end else if (hit) begin
                k_m[i] = 0; tick_m[i] = 1'b0;
            end else if (!run[i]) begin
                k_m[i] = 0; tick_m[i] = 1'b0; done_m[i] = 1'b0;
            end else if (done_m[i]) begin
                k_m[i] = 0; tick_m[i] = 1'b0;
            end else begin
                k_m[i]++;
                tick_m[i] = (k_m[i] % longint'(div_m[i] + 1)) == 0;
                if (tick_m[i] && oneshot[i]) done_m[i] = 1'b1;
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        edge_no++;
        model_edge();
        check({tag, "/tick"}, 32'(tick), 32'(tick_m));
        check({tag, "/done"}, 32'(done), 32'(done_m));
        for (int i = 0; i < N_CH; i++) begin
            if (first_tick[i] < 0 && tick[i]) first_tick[i] = int'(edge_no);
        end
    endtask

    task automatic write_div(input string tag, input int unsigned ch, input int unsigned d);
        wr_en  = 1'b1;
        wr_ch  = 4'(ch);
        wr_div = CNT_W'(d);
        step(tag);
        wr_en  = 1'b0;
    endtask

    task automatic pulse_restart(input string tag);
        sync_restart = 1'b1;
        step(tag);
        sync_restart = 1'b0;
    endtask

    initial begin
        // Reset state and default divisors.
        #1 rst = 1'b1;
        #1;
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("def_div_1hz", 32'(dut_def.g_ch[2].u_ch.div_q), 32'd99_999_999);
        check("def_div_500hz", 32'(dut_def.g_ch[1].u_ch.div_q), 32'd199_999);
        check("def_div_1khz", 32'(dut_def.g_ch[0].u_ch.div_q), 32'd99_999);
        check("def_tick", 32'(tick_def), 32'd0);

        // Free-running periodic channels from reset release.
        model_reset();
        run = 3'b111;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) step("periodic");
        check("first_tick0", 32'(first_tick[0]), 32'd2);
        check("first_tick1", 32'(first_tick[1]), 32'd5);
        check("first_tick2", 32'(first_tick[2]), 32'd10);

        // One-shot on channel 1, then re-arm with a global restart.
        run = 3'b010;
        oneshot = 3'b010;
        write_div("os_wr", 1, 4);
        ch1_ticks = 0;
        for (int c = 0; c < 60; c++) begin
            step("oneshot");
            if (tick[1]) ch1_ticks++;
        end
        check("oneshot_count", ch1_ticks, 32'd1);
        pulse_restart("os_restart");
        repeat (10) step("os_rearm");
        oneshot = '0;
        run = 3'b111;

        // Divisor rewrite mid-count on channel 0.
        write_div("wr7", 0, 7);
        for (int c = 0; c < 20; c++) begin
            if (k_m[0] % 8 == 5) break;
            step("wr7_run");
        end
        write_div("wr2", 0, 2);
        repeat (12) step("wr2_run");

        // Divisor zero, run drop, out-of-range write.
        write_div("wr0", 2, 0);
        repeat (8) step("div0");
        run[2] = 1'b0;
        repeat (2) step("run_low");
        run[2] = 1'b1;
        write_div("wr_oor", 5, 3);
        check("oor_div0", 32'(dut.g_ch[0].u_ch.div_q), div_m[0]);
        check("oor_div1", 32'(dut.g_ch[1].u_ch.div_q), div_m[1]);
        check("oor_div2", 32'(dut.g_ch[2].u_ch.div_q), div_m[2]);
        repeat (20) step("oor_run");

        // Restart coinciding with a channel 0 terminal count.
        write_div("ph1", 1, 6);
        write_div("ph2", 2, 10);
        repeat (7) step("phase");
        for (int c = 0; c < 20; c++) begin
            if ((k_m[0] + 1) % longint'(div_m[0] + 1) == 0) break;
            step("to_term");
        end
        pulse_restart("restart_term");
        check("restart_term_tick0", 32'(tick[0]), 32'd0);
        repeat (30) step("aligned");

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(39, 0) == 0) run[$urandom_range(N_CH - 1, 0)] ^= 1'b1;
            if ($urandom_range(59, 0) == 0) oneshot = N_CH'($urandom);
            sync_restart = ($urandom_range(49, 0) == 0);
            wr_en = ($urandom_range(24, 0) == 0);
            wr_ch = 4'($urandom_range(5, 0));
            wr_div = CNT_W'($urandom_range(12, 0));
            step("rand");
        end
        sync_restart = 1'b0;
        wr_en = 1'b0;

        // Asynchronous reset between clock edges.
        run = 3'b111;
        oneshot = 3'b010;
        write_div("ar_wr2", 2, 0);
        write_div("ar_wr1", 1, 1);
        repeat (5) step("ar_setup");
        check("ar_pre_tick2", 32'(tick[2]), 32'd1);
        check("ar_pre_done1", 32'(done[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_tick", 32'(tick), 32'd0);
        check("async_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("ar_div0", 32'(dut.g_ch[0].u_ch.div_q), 32'd1);
        check("ar_div1", 32'(dut.g_ch[1].u_ch.div_q), 32'd4);
        check("ar_div2", 32'(dut.g_ch[2].u_ch.div_q), 32'd9);
        check("ar_def_1hz", 32'(dut_def.g_ch[2].u_ch.div_q), 32'd99_999_999);
        oneshot = '0;
        model_reset();
        rst = 1'b0;
        repeat (12) step("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
